// File: rtl/little_pkg.sv
// little_pkg: shared widths and FSM state codes
// for the little packer/unpacker pair.
package little_pkg;

  localparam int BYTE_W = 8;
  localparam int WORD_W = 16;
  localparam int TAG_W  = 32;

  typedef logic [7:0] fsm_state_t;

  localparam fsm_state_t IDLE   = 8'd0;
  localparam fsm_state_t FIRST  = 8'd1;
  localparam fsm_state_t SECOND = 8'd2;

endpackage

// File: rtl/little_unpacker_if.sv
// little_unpacker_if: word-in / byte-out
// valid/ready bundle of the unpacker.
interface little_unpacker_if;
  import little_pkg::*;

  logic [WORD_W-1:0] mIn;
  logic              inValid;
  logic              inReady;
  logic [TAG_W-1:0]  inFoo;
  logic [BYTE_W-1:0] mOut;
  logic              outValid;
  logic              outReady;
  logic [TAG_W-1:0]  outFoo;

  modport master (
    output mIn, inValid, inFoo, outReady,
    input  inReady, mOut, outValid, outFoo
  );

  modport slave (
    input  mIn, inValid, inFoo, outReady,
    output inReady, mOut, outValid, outFoo
  );

endinterface

// File: rtl/little_mirror_check.sv
// little_mirror_check: flags words whose two
// halves differ and counts them (saturating).
module little_mirror_check
  import little_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              accept_i,
  input  logic [WORD_W-1:0] word_i,
  output logic              err_o,
  output logic [7:0]        cnt_o
);

  logic       err_q, err_d;
  logic [7:0] cnt_q, cnt_d;
  logic       mism;

  assign mism =
    word_i[WORD_W-1:BYTE_W] != word_i[BYTE_W-1:0];

  // flag follows the accepted word; count saturates
  always_comb begin
    err_d = err_q;
    cnt_d = cnt_q;
    if (accept_i) begin
      err_d = mism;
      if (mism && cnt_q != 8'hFF)
        cnt_d = cnt_q + 8'd1;
    end
  end

  // flag and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
      cnt_q <= 8'd0;
    end else begin
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  assign err_o = err_q;
  assign cnt_o = cnt_q;

endmodule

// File: rtl/little_unpacker.sv
// little_unpacker: 16-bit word to two bytes.
// Optional LITTLE_UNPACKER_MIRROR_CHECK_EN.
module little_unpacker
  import little_pkg::*;
#(
  parameter bit HI_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         reset,
  little_unpacker_if.slave io
`ifdef LITTLE_UNPACKER_MIRROR_CHECK_EN
  ,
  output logic         mirrorErr,
  output logic [7:0]   errCount
`endif
);

  fsm_state_t        state_q, state_d;
  logic [BYTE_W-1:0] mout_q, mout_d;
  logic [BYTE_W-1:0] held_q, held_d;
  logic [TAG_W-1:0]  foo_q, foo_d;
  logic              vld_q, vld_d;
  logic              accept;
  logic [BYTE_W-1:0] hi_b, lo_b;
  logic [BYTE_W-1:0] first_b, second_b;

  assign hi_b     = io.mIn[WORD_W-1:BYTE_W];
  assign lo_b     = io.mIn[BYTE_W-1:0];
  assign first_b  = HI_FIRST ? hi_b : lo_b;
  assign second_b = HI_FIRST ? lo_b : hi_b;

  assign io.inReady = (state_q == IDLE) |
    ((state_q == SECOND) & io.outReady);
  assign accept = io.inValid & io.inReady;

  // state and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      mout_q  <= '0;
      held_q  <= '0;
      foo_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mout_q  <= mout_d;
      held_q  <= held_d;
      foo_q   <= foo_d;
      vld_q   <= vld_d;
    end
  end

  // next state
  always_comb begin
    state_d = IDLE;
    unique case (1'b1)
      state_q == IDLE:
        state_d = accept ? FIRST : IDLE;
      state_q == FIRST:
        state_d = io.outReady ? SECOND : FIRST;
      state_q == SECOND:
        state_d = !io.outReady ? SECOND :
                  accept ? FIRST : IDLE;
      default:
        state_d = IDLE;
    endcase
  end

  // byte, tag and valid for the next cycle
  always_comb begin
    mout_d = mout_q;
    held_d = held_q;
    foo_d  = foo_q;
    vld_d  = vld_q;
    unique case (1'b1)
      state_q == IDLE,
      state_q == SECOND: begin
        if (accept) begin
          mout_d = first_b;
          held_d = second_b;
          foo_d  = io.inFoo;
          vld_d  = 1'b1;
        end else if (state_q == IDLE ||
                     io.outReady) begin
          vld_d = 1'b0;
        end
      end
      state_q == FIRST: begin
        if (io.outReady)
          mout_d = held_q;
      end
      default:
        vld_d = 1'b0;
    endcase
  end

  assign io.mOut     = mout_q;
  assign io.outFoo   = foo_q;
  assign io.outValid = vld_q;

`ifdef LITTLE_UNPACKER_MIRROR_CHECK_EN
  little_mirror_check u_mirror (
    .clk      (clk),
    .rst_n    (reset),
    .accept_i (accept),
    .word_i   (io.mIn),
    .err_o    (mirrorErr),
    .cnt_o    (errCount)
  );
`endif

endmodule

// File: doc/little_unpacker.md
Name: little_unpacker

Overview:
- Inverse of the byte-duplicating packer: accepts one 16-bit word and emits it as two serial 8-bit bytes with a valid/ready handshake on both sides.
- A 32-bit sideband tag travels with each word and is presented alongside both of its bytes.
- Sits downstream of the packer on the 16-bit path and feeds byte-wide consumers.
- Sustains one byte per clock under continuous traffic.

Parameters:
- HI_FIRST, 1: 1 = first byte emitted is mIn[15:8], second is mIn[7:0]; 0 = reversed.

Ports:
- clk  input  1  single clock, all logic on its rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- mIn  input  16  word to unpack.
- inValid  input  1  mIn/inFoo valid.
- inReady  output  1  block can accept a word this cycle (combinational).
- inFoo  input  32  sideband tag captured with the word.
- mOut  output  8  current byte (registered).
- outValid  output  1  mOut/outFoo valid (registered).
- outReady  input  1  consumer takes the byte this cycle.
- outFoo  output  32  tag of the word mOut belongs to (registered).

Behaviour:
- Reset (async, reset==0): fsmState=IDLE; mOut=0, outValid=0, outFoo=0, held word=0. Takes effect immediately. Any word or byte in flight is discarded, with no partial output after release.
- inReady = (fsmState==IDLE) | (fsmState==SECOND & outReady). A word is accepted when inValid & inReady.
- Encoding: firstByte = HI_FIRST ? mIn[15:8] : mIn[7:0]; secondByte is the other half.
- FSM states, encoded in 8-bit fsmState: IDLE=0, FIRST=1, SECOND=2. Any other value goes to IDLE with outValid=0.
- IDLE:
  - On accept: mOut<=firstByte, outFoo<=inFoo, outValid<=1, store secondByte; go to FIRST.
  - Otherwise hold, outValid=0.
- FIRST:
  - On outReady: mOut<=stored secondByte, outFoo unchanged; go to SECOND.
  - Otherwise hold mOut/outFoo/outValid stable.
- SECOND:
  - outReady & inValid: load the new word as in IDLE; go to FIRST. This is back-to-back, with no bubble.
  - outReady & !inValid: outValid<=0; go to IDLE.
  - !outReady: hold everything stable. inReady=0, and any word offered is not taken.
- Latency: word accepted in cycle N gives first byte valid in N+1 and second byte in N+2 at the earliest. Sustained throughput is 2 cycles per word.
- Stability rule: while outValid=1 and outReady=0, mOut and outFoo do not change.
- inValid is ignored in FIRST. No input data is lost, because inReady=0 there.

Optional Feature:
- Macro LITTLE_UNPACKER_MIRROR_CHECK_EN.
- Defined:
  - Adds output mirrorErr (1 bit, registered). It is loaded on word accept with (mIn[15:8]!=mIn[7:0]) and held for both bytes of that word. Reset value 0.
  - Adds output errCount (8 bits). It increments on each accepted mismatching word, saturates at 255, and resets to 0.
- Undefined: both ports and all associated logic are absent. Behaviour is otherwise identical.

Decomposition:
- Shared package little_pkg holds:
  - BYTE_W=8, WORD_W=16, TAG_W=32.
  - FSM state constants IDLE/FIRST/SECOND as an 8-bit typedef, reused by the packer.
- One natural sub-module: little_mirror_check (compare, saturating counter), instantiated only under the macro.

Test Plan:
- Single word: reset released, mIn=16'hA55A, inFoo=32'h1, outReady=1 -> mOut=8'hA5 then 8'h5A on consecutive cycles, outFoo=1 on both, then outValid=0.
- Back-to-back: 16'h1234 then 16'h5678 with inValid held high and outReady=1 -> bytes 12,34,56,78 on four consecutive cycles; inReady is low in FIRST and high in SECOND.
- Backpressure: outReady=0 for 5 cycles after the first byte of 16'hBEEF -> mOut=8'hBE stable throughout, inReady=0; after outReady=1, 8'hEF follows.
- HI_FIRST=0: mIn=16'hCAFE -> 8'hFE then 8'hCA.
- Reset mid-word: assert reset while in SECOND -> outValid=0 immediately; after release, no stale byte appears and the first new word is emitted correctly.
- Macro defined: words 16'h7777, 16'h7701 -> mirrorErr 0 then 1, errCount=1; 300 mismatching words -> errCount=255.
